// File: rtl/rf_regfile.sv
// rf_regfile: NUM_REGS x BUS_WIDTH register file with one write port and two
// independently enabled registered read ports. Register 0 can be hard-wired
// to zero, a same-cycle write is bypassed to the read ports, and each
// register carries a "written since reset" flag that is returned as init_*.
module rf_regfile #(
  parameter int BUS_WIDTH  = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BUS_WIDTH-1:0]  wr_data,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [BUS_WIDTH-1:0]  out_a,
  output logic                  init_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [BUS_WIDTH-1:0]  out_b,
  output logic                  init_b
);

  // One extra bit so NUM_REGS = 2^ADDR_WIDTH still fits for the range compare.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  logic [BUS_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]  written_q;
  logic                 wr_eff;
  logic [BUS_WIDTH-1:0] out_a_d, out_b_d;
  logic                 init_a_d, init_b_d;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < NUM_REGS_W;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG == 1) && (addr == '0);
  endfunction

  // Read selection shared by both ports: {init, data} as seen after this edge.
  function automatic logic [BUS_WIDTH:0] read_sel(input logic [ADDR_WIDTH-1:0] addr);
    logic [BUS_WIDTH:0] res;
    res = '0;
    if (!in_range(addr)) begin
      res = '0;
    end else if (is_zero_reg(addr)) begin
      res = {1'b1, {BUS_WIDTH{1'b0}}};
    end else if (wr_eff && (wr_addr == addr)) begin
      res = {1'b1, wr_data};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == i[ADDR_WIDTH-1:0]) res = {written_q[i], regs_q[i]};
      end
    end
    return res;
  endfunction

  // Decide whether this cycle's write lands in a real, writable register.
  always_comb begin
    wr_eff = regWrite && in_range(wr_addr) && !is_zero_reg(wr_addr);
  end

  // Next read data for both ports, including same-cycle write bypass.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    out_a_d  = '0;
    init_a_d = 1'b0;
    out_b_d  = '0;
    init_b_d = 1'b0;
    {init_a_d, out_a_d} = read_sel(rd_addr_a);
    {init_b_d, out_b_d} = read_sel(rd_addr_b);
  end

  // Register storage and written flags; only effective writes touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is cleared on reset because reads after reset must return 0.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      written_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_eff && (wr_addr == i[ADDR_WIDTH-1:0])) begin
          // NOTE: non-blocking so every flop samples pre-edge values.
          regs_q[i]    <= wr_data;
          written_q[i] <= 1'b1;
        end
      end
    end
  end

  // Registered read ports; a disabled port holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a  <= '0;
      init_a <= 1'b0;
      out_b  <= '0;
      init_b <= 1'b0;
    end else begin
      if (rd_en_a) begin
        out_a  <= out_a_d;
        init_a <= init_a_d;
      end
      if (rd_en_b) begin
        out_b  <= out_b_d;
        init_b <= init_b_d;
      end
    end
  end

endmodule

// File: tb/tb_rf_regfile.sv
// Bench for rf_regfile: three instances (8 regs with zero reg, 8 regs without,
// 6 regs with zero reg) share one stimulus stream; a reference model pushes
// expected outputs into a scoreboard queue and they are compared after the edge.
module tb_rf_regfile;

  localparam int NCFG = 3;

  logic        clk;
  logic        rst_n;
  logic        regWrite;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en_a, rd_en_b;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] out_a [NCFG];
  logic [15:0] out_b [NCFG];
  logic        init_a [NCFG];
  logic        init_b [NCFG];

  int n_checks = 0;
  int n_errors = 0;

  int cfg_n [NCFG] = '{8, 8, 6};
  bit cfg_z [NCFG] = '{1'b1, 1'b0, 1'b1};

  logic [15:0] m_reg [NCFG][8];
  logic        m_wr  [NCFG][8];
  logic [15:0] m_oa [NCFG];
  logic [15:0] m_ob [NCFG];
  logic        m_ia [NCFG];
  logic        m_ib [NCFG];

  typedef struct {
    string            tag;
    logic [2:0][15:0] oa;
    logic [2:0][15:0] ob;
    logic [2:0]       ia;
    logic [2:0]       ib;
  } exp_t;

  exp_t sb_q[$];

  rf_regfile #(.BUS_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .out_a(out_a[0]), .init_a(init_a[0]),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .out_b(out_b[0]), .init_b(init_b[0])
  );

  rf_regfile #(.BUS_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .out_a(out_a[1]), .init_a(init_a[1]),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .out_b(out_b[1]), .init_b(init_b[1])
  );

  rf_regfile #(.BUS_WIDTH(16), .NUM_REGS(6), .ADDR_WIDTH(3), .ZERO_REG(1)) u_dut_6 (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .out_a(out_a[2]), .init_a(init_a[2]),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .out_b(out_b[2]), .init_b(init_b[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      for (int r = 0; r < 8; r++) begin
        m_reg[c][r] = '0;
        m_wr[c][r]  = 1'b0;
      end
      m_oa[c] = '0; m_ob[c] = '0; m_ia[c] = 1'b0; m_ib[c] = 1'b0;
    end
  endtask

  function automatic bit model_weff(int c, logic we, logic [2:0] wa);
    return we && (int'(wa) < cfg_n[c]) && !(cfg_z[c] && wa == 3'd0);
  endfunction

  task automatic model_read(input int c, input logic we, input logic [2:0] wa,
                            input logic [15:0] wd, input logic [2:0] a,
                            output logic [15:0] d, output logic i);
    if (int'(a) >= cfg_n[c]) begin
      d = '0; i = 1'b0;
    end else if (cfg_z[c] && a == 3'd0) begin
      d = '0; i = 1'b1;
    end else if (model_weff(c, we, wa) && wa == a) begin
      d = wd; i = 1'b1;
    end else begin
      d = m_reg[c][a]; i = m_wr[c][a];
    end
  endtask

  // Drive one cycle of stimulus, push the expected outputs, compare after the edge.
  task automatic cycle(input string tag, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic ea, input logic [2:0] aa,
                       input logic eb, input logic [2:0] ab);
    exp_t e;
    exp_t got;
    logic [15:0] d;
    logic        i;
    @(negedge clk);
    regWrite = we; wr_addr = wa; wr_data = wd;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    for (int c = 0; c < NCFG; c++) begin
      if (ea) begin model_read(c, we, wa, wd, aa, d, i); m_oa[c] = d; m_ia[c] = i; end
      if (eb) begin model_read(c, we, wa, wd, ab, d, i); m_ob[c] = d; m_ib[c] = i; end
      if (model_weff(c, we, wa)) begin m_reg[c][wa] = wd; m_wr[c][wa] = 1'b1; end
      e.oa[c] = m_oa[c]; e.ob[c] = m_ob[c]; e.ia[c] = m_ia[c]; e.ib[c] = m_ib[c];
    end
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      for (int c = 0; c < NCFG; c++) begin
        check($sformatf("%s/c%0d/out_a", got.tag, c),  {16'd0, out_a[c]}, {16'd0, got.oa[c]});
        check($sformatf("%s/c%0d/init_a", got.tag, c), {31'd0, init_a[c]}, {31'd0, got.ia[c]});
        check($sformatf("%s/c%0d/out_b", got.tag, c),  {16'd0, out_b[c]}, {16'd0, got.ob[c]});
        check($sformatf("%s/c%0d/init_b", got.tag, c), {31'd0, init_b[c]}, {31'd0, got.ib[c]});
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("%s/c%0d/out_a", tag, c),  {16'd0, out_a[c]}, 32'd0);
      check($sformatf("%s/c%0d/init_a", tag, c), {31'd0, init_a[c]}, 32'd0);
      check($sformatf("%s/c%0d/out_b", tag, c),  {16'd0, out_b[c]}, 32'd0);
      check($sformatf("%s/c%0d/init_b", tag, c), {31'd0, init_b[c]}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    regWrite = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
    model_reset();
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every register with 16'hFFFF, then read so the outputs are non-zero.
    for (int r = 0; r < 8; r++) cycle("fill", 1'b1, 3'(r), 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("pre_rst_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd5);

    // Asynchronous reset away from any clock edge; a write held during reset is lost.
    @(negedge clk);
    rst_n = 1'b0;
    regWrite = 1'b1; wr_addr = 3'd3; wr_data = 16'hFFFF;
    rd_en_a = 1'b1; rd_addr_a = 3'd3; rd_en_b = 1'b1; rd_addr_b = 3'd3;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    regWrite = 1'b0;
    cycle("post_rst_r3", 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd3);

    // Write then read on the following cycle.
    cycle("wr_r2", 1'b1, 3'd2, 16'h0F0F, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("rd_r2_r5", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b1, 3'd5);

    // Same-cycle write and dual read of the same address.
    cycle("bypass_r4", 1'b1, 3'd4, 16'hBEEF, 1'b1, 3'd4, 1'b1, 3'd4);

    // Write to a different address than the one being read returns old content.
    cycle("rd_old", 1'b1, 3'd5, 16'h5A5A, 1'b1, 3'd2, 1'b1, 3'd4);

    // Register 0: hard-wired zero on two instances, ordinary on the other.
    cycle("wr_r0", 1'b1, 3'd0, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("rd_r0", 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b1, 3'd0);

    // Hold: port A disabled while its register is overwritten.
    cycle("rd_r2_hold", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) cycle("hold", 1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd2, 1'b0, 3'd0);

    // Address 7 is out of range on the 6-register instance.
    cycle("wr_a7", 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("rd_a7", 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 1'b1, 3'd6);
    for (int r = 0; r < 8; r++) cycle("sweep", 1'b0, 3'd0, 16'h0, 1'b1, 3'(r), 1'b1, 3'(7 - r));

    // Random traffic on all ports.
    for (int k = 0; k < 300; k++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
